// File: rtl/funcq_solve_b_if.sv
// Handshake bundle for funcq_solve_b. Both sides use valid/ready: a set or
// result moves on a rising clk edge where valid and ready are both high.
interface funcq_solve_b_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] c;
  logic [DATA_WIDTH-1:0] d;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] b;
  logic                  exact;
  logic                  ovf;

  modport master (
    output in_vld, q, a, c, d, out_rdy,
    input  in_rdy, out_vld, b, exact, ovf
  );

  modport slave (
    input  in_vld, q, a, c, d, out_rdy,
    output in_rdy, out_vld, b, exact, ovf
  );
endinterface

// File: rtl/funcq_solve_b.sv
// Recovers b = a - (2q + 4d)/(1 + 3c) with a radix-2 restoring divider.
// Optional macro FUNCQ_SOLVE_SAT_EN: saturate b and report clamping on ovf.
module funcq_solve_b #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  funcq_solve_b_if.slave      bus,
  output logic [2:0]          dbg_state
);
  localparam int DW = DATA_WIDTH;
  localparam int NW = DATA_WIDTH + 3;
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] q_r, a_r, c_r, d_r;
  logic [NW-1:0] den_mag;
  logic [NW-1:0] dvd;      // dividend shifts out the top, quotient bits enter the bottom
  logic [NW:0]   rem;
  logic          neg;
  logic [CW-1:0] cnt;
  logic          in_rdy_r, out_vld_r, exact_r;
  logic [DW-1:0] b_r;

  // Operand forming at NW bits; the magnitudes cannot overflow.
  logic [NW-1:0] q_x, c_x, d_x, num_w, den_w, num_abs, den_abs;
  always_comb begin
    q_x     = {{3{q_r[DW-1]}}, q_r};
    c_x     = {{3{c_r[DW-1]}}, c_r};
    d_x     = {{3{d_r[DW-1]}}, d_r};
    num_w   = {q_x[NW-2:0], 1'b0} + {d_x[NW-3:0], 2'b00};
    den_w   = {c_x[NW-2:0], 1'b0} + c_x + {{(NW-1){1'b0}}, 1'b1};
    num_abs = num_w[NW-1] ? (~num_w + 1'b1) : num_w;
    den_abs = den_w[NW-1] ? (~den_w + 1'b1) : den_w;
  end

  logic [NW:0] rem_sh, rem_sub;
  logic        take;
  always_comb begin
    rem_sh  = {rem[NW-1:0], dvd[NW-1]};
    rem_sub = rem_sh - {1'b0, den_mag};
    take    = (rem_sh >= {1'b0, den_mag});
  end

  logic [DW-1:0] b_next;
  logic          ovf_next;
`ifdef FUNCQ_SOLVE_SAT_EN
  logic [NW-1:0] quot_s;
  logic [NW:0]   b_full;
  logic          fits;
  logic          ovf_r;
  always_comb begin
    quot_s = neg ? (~dvd + 1'b1) : dvd;
    b_full = {{4{a_r[DW-1]}}, a_r} - {quot_s[NW-1], quot_s};
    fits   = (b_full[NW:DW-1] == {(NW-DW+2){b_full[DW-1]}});
    ovf_next = ~fits;
    if (fits)
      b_next = b_full[DW-1:0];
    else if (b_full[NW])
      b_next = {1'b1, {(DW-1){1'b0}}};
    else
      b_next = {1'b0, {(DW-1){1'b1}}};
  end
`else
  // Wrapping keeps only the low DW bits, so the subtraction is done at DW.
  logic [DW-1:0] quot_lo;
  always_comb begin
    quot_lo  = neg ? (~dvd[DW-1:0] + 1'b1) : dvd[DW-1:0];
    b_next   = a_r - quot_lo;
    ovf_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q_r       <= '0;
      a_r       <= '0;
      c_r       <= '0;
      d_r       <= '0;
      den_mag   <= '0;
      dvd       <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      in_rdy_r  <= 1'b1;
      out_vld_r <= 1'b0;
      exact_r   <= 1'b0;
      b_r       <= '0;
`ifdef FUNCQ_SOLVE_SAT_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_vld) begin
            q_r      <= bus.q;
            a_r      <= bus.a;
            c_r      <= bus.c;
            d_r      <= bus.d;
            in_rdy_r <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          dvd     <= num_abs;
          den_mag <= den_abs;
          neg     <= num_w[NW-1] ^ den_w[NW-1];
          rem     <= '0;
          cnt     <= '0;
          state   <= DIV;
        end
        DIV: begin
          rem <= take ? rem_sub : rem_sh;
          dvd <= {dvd[NW-2:0], take};
          if (cnt == CW'(NW - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          b_r       <= b_next;
          exact_r   <= (rem == '0);
`ifdef FUNCQ_SOLVE_SAT_EN
          ovf_r     <= ovf_next;
`endif
          out_vld_r <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_rdy) begin
            out_vld_r <= 1'b0;
            in_rdy_r  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_r;
  assign bus.out_vld = out_vld_r;
  assign bus.b       = b_r;
  assign bus.exact   = exact_r;
`ifdef FUNCQ_SOLVE_SAT_EN
  assign bus.ovf     = ovf_r;
`else
  assign bus.ovf     = ovf_next;
`endif
  assign dbg_state   = state;
endmodule

// File: doc/funcq_solve_b.md
# funcq_solve_b

- Sequential inverse of the team's pipelined Q-evaluator `Q = ((a-b)*(1+3c) - 4d)/2`.
- Given Q together with the matching a, c, d, it recovers b with the formula `b = a - (2Q + 4d)/(1+3c)`.
- The divide is a multi-cycle radix-2 restoring divider wrapped in a valid/ready handshake.
- It sits downstream of the evaluator's result stream and is used for self-check and for parameter back-solving.

## Interface
Parameters:
- DATA_WIDTH, 16, width of q, a, c, d and b (signed two's complement).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_vld  in  1  input set q/a/c/d is valid.
- in_rdy  out  1  block is idle and accepts a set.
- q  in  DATA_WIDTH  signed Q value.
- a  in  DATA_WIDTH  signed.
- c  in  DATA_WIDTH  signed.
- d  in  DATA_WIDTH  signed.
- out_vld  out  1  result valid; held until it is accepted.
- out_rdy  in  1  consumer accepts the result.
- b  out  DATA_WIDTH  signed recovered b.
- exact  out  1  division remainder was zero.
- ovf  out  1  the full-precision b did not fit in DATA_WIDTH.

## Operation
- Internal width NW = DATA_WIDTH+3, signed.
- Numerator: num = 2*q + 4*d, computed at NW bits with no overflow possible.
- Denominator: den = 1 + 3*c, computed at NW bits.
  - den is never 0 for integer c, so there is no divide-by-zero path.
- Quotient:
  - Divide |num| by |den| unsigned, one quotient bit per cycle, MSB first, NW iterations.
  - quot = ±(|num|/|den|): negative when the signs of num and den differ. The result truncates toward zero.
  - exact = 1 when the unsigned remainder is 0.
- Result: b_full = a - quot, at NW+1 bits. It is reduced to DATA_WIDTH per the Configuration section.
- The lost LSB of the forward `>>>1` cannot be recovered. For an odd forward intermediate, exact=0 and b may differ from the original.
- FSM states and transitions:
  - IDLE: in_rdy=1. When in_vld is high, capture q/a/c/d and go to PREP.
  - PREP: compute num, den and their magnitudes and signs; clear the remainder and iteration counter; go to DIV.
  - DIV: one shift/subtract per cycle. The counter runs 0..NW-1; after the NW-th iteration go to FIX.
  - FIX: apply signs, compute b, exact and ovf; set out_vld=1; go to DONE.
  - DONE: hold out_vld, b, exact and ovf stable. On out_rdy, clear out_vld and go to IDLE.
- in_rdy is high only in IDLE. in_vld in any other state is ignored and nothing is captured.
- b, exact and ovf keep their last values after the handshake until the next FIX.

## Timing
- Reset values: state IDLE, in_rdy=1, out_vld=0, b=0, exact=0, ovf=0, counter=0.
- Latency:
  - Input accepted at edge T.
  - out_vld rises at edge T+NW+2 (21 cycles for DATA_WIDTH=16).
- Output handshake: out_vld && out_rdy at edge U clears out_vld, and in_rdy=1 from edge U.
  - The next accept is possible at edge U+1.
  - If out_rdy is already high when out_vld rises, the result is held for exactly one cycle.
- Throughput: one result per NW+4 cycles minimum, with no overlap.
- Reset mid-operation: async rst forces the reset values immediately. The in-flight computation is discarded and no out_vld is produced.
- out_rdy while out_vld=0 has no effect.

## Configuration
- FUNCQ_SOLVE_SAT_EN:
  - Defined: b saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and ovf=1 when clamping occurred.
  - Undefined: b = b_full[DATA_WIDTH-1:0] (two's-complement wrap), and ovf is tied to 0.

## Test plan
- Exact, DATA_WIDTH=16: q=8, a=10, c=1, d=2 -> b=4, exact=1, ovf=0; out_vld rises exactly 21 cycles after the accept edge.
- Negative operands: q=32, a=-5, c=-3, d=0 -> num=64, den=-8, b=3, exact=1.
- Truncation toward zero: q=-5, a=0, c=1, d=0 -> num=-10, den=4, quot=-2, b=2, exact=0.
- Range limit: q=-32768, a=0, c=0, d=0 -> b_full=65536.
  - With FUNCQ_SOLVE_SAT_EN: b=32767, ovf=1.
  - Without it: b=0, ovf=0.
- Backpressure: hold out_rdy=0 for 10 cycles after out_vld.
  - b, exact and out_vld stay stable and in_rdy stays 0.
  - in_vld pulses with other data are ignored.
  - Release out_rdy -> one transfer, then in_rdy=1.
- Reset mid-DIV: assert rst 5 cycles after accept -> out_vld=0 and in_rdy=1 immediately. A following set q=8, a=10, c=1, d=2 returns b=4 with normal latency.
